// File: rtl/dpwm_pkg.sv
// Shared definitions for the digital PWM core: default resolution, the
// minimum runnable period and the modulator FSM state type.
package dpwm_pkg;

    localparam int unsigned RESOLUTION_DEF = 12;
    localparam int unsigned MIN_PERIOD     = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dpwm_state_e;

endpackage

// File: rtl/dpwm_ramp_counter.sv
// Ramp counter for the DPWM: counts 0..effective_period-1 while running,
// flags the terminal count and wraps; held at zero whenever not running.
module dpwm_ramp_counter
    import dpwm_pkg::*;
#(
    parameter int unsigned RESOLUTION = RESOLUTION_DEF
) (
    input  logic                  hf_clock,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic [RESOLUTION-1:0] period_active,
    output logic [RESOLUTION-1:0] count,
    output logic                  tc
);

    logic [RESOLUTION-1:0] last_s;
    logic [RESOLUTION-1:0] count_r;

    // Terminal count value; periods below the minimum are stretched up to it.
    always_comb begin
        last_s = period_active - RESOLUTION'(1);
        if (period_active < RESOLUTION'(MIN_PERIOD)) begin
            last_s = RESOLUTION'(MIN_PERIOD - 1);
        end else begin
            last_s = period_active - RESOLUTION'(1);
        end
    end

    assign tc    = (count_r == last_s);
    assign count = count_r;

    // Ramp register: cleared when idle or on the start edge, wraps at TC.
    always_ff @(posedge hf_clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (!run) begin
            count_r <= '0;
        end else if (tc) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + RESOLUTION'(1);
        end
    end

endmodule

// File: rtl/dpwm_core.sv
// Digital PWM modulator: double-buffered period/duty, ramp compare and
// complementary high/low-side outputs for a downstream deadtime stage.
module dpwm_core
    import dpwm_pkg::*;
#(
    parameter int unsigned RESOLUTION = RESOLUTION_DEF
) (
    input  logic                  hf_clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [RESOLUTION-1:0] period,
    input  logic [RESOLUTION-1:0] duty,
    input  logic                  load,
    output logic                  HPWM,
    output logic                  LPWM,
    output logic [RESOLUTION-1:0] count,
    output logic                  period_start,
    output logic                  load_ack
);

    logic                  rst_meta_r;
    logic                  rst_sync_r;
    dpwm_state_e           state_r;
    dpwm_state_e           state_next_s;
    logic                  start_s;
    logic                  run_s;
    logic                  tc_s;
    logic                  wrap_s;
    logic                  xfer_s;
    logic                  high_s;
    logic [RESOLUTION-1:0] shadow_period_r;
    logic [RESOLUTION-1:0] shadow_duty_r;
    logic [RESOLUTION-1:0] active_period_r;
    logic [RESOLUTION-1:0] active_duty_r;
    logic                  pending_r;
    logic                  hpwm_r;
    logic                  lpwm_r;
    logic                  period_start_r;
    logic                  load_ack_r;

    // Reset release synchroniser; assertion stays asynchronous.
    always_ff @(posedge hf_clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge hf_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: run only once the reset release has been synchronised.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (enable && rst_sync_r) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (enable && rst_sync_r) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // A boundary is either the start edge or a wrap; shadows move only there.
    assign start_s = (state_r == ST_IDLE) && (state_next_s == ST_RUN);
    assign run_s   = (state_r == ST_RUN)  && (state_next_s == ST_RUN);
    assign wrap_s  = run_s && tc_s;
    assign xfer_s  = start_s || (wrap_s && pending_r);
    assign high_s  = (count < active_duty_r);

    dpwm_ramp_counter #(
        .RESOLUTION (RESOLUTION)
    ) u_ramp (
        .hf_clock      (hf_clock),
        .reset_n       (reset_n),
        .run           (run_s),
        .period_active (active_period_r),
        .count         (count),
        .tc            (tc_s)
    );

    // Shadow registers and pending flag; a new load wins over a same-edge transfer.
    always_ff @(posedge hf_clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_period_r <= '1;
            shadow_duty_r   <= '0;
            pending_r       <= 1'b0;
        end else begin
            if (load) begin
                shadow_period_r <= period;
                shadow_duty_r   <= duty;
                pending_r       <= 1'b1;
            end else if (xfer_s) begin
                pending_r       <= 1'b0;
            end else begin
                pending_r       <= pending_r;
            end
        end
    end

    // Active registers: take the pre-load shadow values at a boundary.
    always_ff @(posedge hf_clock or negedge reset_n) begin
        if (!reset_n) begin
            active_period_r <= '1;
            active_duty_r   <= '0;
        end else if (xfer_s) begin
            active_period_r <= shadow_period_r;
            active_duty_r   <= shadow_duty_r;
        end else begin
            active_period_r <= active_period_r;
            active_duty_r   <= active_duty_r;
        end
    end

    // Registered outputs; both PWM legs are low whenever not running.
    always_ff @(posedge hf_clock or negedge reset_n) begin
        if (!reset_n) begin
            hpwm_r         <= 1'b0;
            lpwm_r         <= 1'b0;
            period_start_r <= 1'b0;
            load_ack_r     <= 1'b0;
        end else begin
            if (run_s) begin
                hpwm_r <= high_s;
                lpwm_r <= ~high_s;
            end else begin
                hpwm_r <= 1'b0;
                lpwm_r <= 1'b0;
            end
            period_start_r <= start_s || wrap_s;
            load_ack_r     <= (start_s || wrap_s) && pending_r;
        end
    end

    assign HPWM         = hpwm_r;
    assign LPWM         = lpwm_r;
    assign period_start = period_start_r;
    assign load_ack     = load_ack_r;

endmodule

// File: tb/tb_dpwm_core.sv
// Self-checking bench for dpwm_core: per-cycle reference model, a table of
// steady-state period/duty cases and hand sequences for reload/enable/reset.
module tb_dpwm_core;

    localparam int R    = 12;
    localparam int PMAX = (1 << R) - 1;

    logic          hf_clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          load;
    logic [R-1:0]  period;
    logic [R-1:0]  duty;
    logic          HPWM;
    logic          LPWM;
    logic [R-1:0]  count;
    logic          period_start;
    logic          load_ack;

    int total = 0;
    int bad   = 0;

    // reference model state: phase within period (-1 = not running)
    int m_ph, a_p, a_d, s_p, s_d, rel_edges, e_cnt;
    bit pend, e_hp, e_lp, e_ps, e_ack;

    typedef struct {
        int p;
        int d;
        int exp_per;
        int exp_hi;
        int exp_lo;
    } vec_t;
    vec_t vecs [8];

    always #5 hf_clock = ~hf_clock;

    dpwm_core #(.RESOLUTION(R)) dut (
        .hf_clock     (hf_clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .period       (period),
        .duty         (duty),
        .load         (load),
        .HPWM         (HPWM),
        .LPWM         (LPWM),
        .count        (count),
        .period_start (period_start),
        .load_ack     (load_ack)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = -1; a_p = PMAX; a_d = 0; s_p = PMAX; s_d = 0;
        pend = 1'b0; rel_edges = 0;
        e_hp = 1'b0; e_lp = 1'b0; e_ps = 1'b0; e_ack = 1'b0; e_cnt = 0;
    endtask

    // One rising edge of the specified behaviour, in terms of period phase.
    task automatic model_edge();
        int eff, prev_ph, prev_d;
        bit ok, go, prev_pend;
        if (!reset_n) return;
        ok = (rel_edges >= 2);
        if (rel_edges < 1000) rel_edges++;
        go = ok && enable;
        prev_ph = m_ph; prev_d = a_d; prev_pend = pend;
        eff = (a_p < 2) ? 2 : a_p;
        e_ps = 1'b0; e_ack = 1'b0; e_hp = 1'b0; e_lp = 1'b0;
        if (!go) begin
            m_ph = -1;
        end else begin
            if (prev_ph >= 0) begin
                e_hp = (prev_ph < prev_d);
                e_lp = !e_hp;
            end
            if (prev_ph < 0 || prev_ph == eff - 1) begin
                e_ps  = 1'b1;
                e_ack = prev_pend;
                if (prev_ph < 0 || prev_pend) begin
                    a_p = s_p; a_d = s_d; pend = 1'b0;
                end
                m_ph = 0;
            end else begin
                m_ph = prev_ph + 1;
            end
        end
        if (load) begin
            s_p = int'(period); s_d = int'(duty); pend = 1'b1;
        end
        e_cnt = (m_ph < 0) ? 0 : m_ph;
    endtask

    task automatic check_all();
        chk("hpwm", int'(HPWM), int'(e_hp));
        chk("lpwm", int'(LPWM), int'(e_lp));
        chk("count", int'(count), e_cnt);
        chk("period_start", int'(period_start), int'(e_ps));
        chk("load_ack", int'(load_ack), int'(e_ack));
        chk("overlap", int'(HPWM && LPWM), 0);
    endtask

    task automatic tick();
        @(posedge hf_clock);
        model_edge();
        #1;
        check_all();
    endtask

    // Measures the period window starting at the next period_start pulse.
    task automatic measure(output int per, output int hi, output int lo);
        int n;
        n = 0;
        per = -1; hi = -1; lo = -1;
        while (!period_start && n < 10000) begin tick(); n++; end
        if (!period_start) begin
            chk("ps_timeout", int'(period_start), 1);
            return;
        end
        per = 0; hi = 0; lo = 0;
        do begin
            hi += int'(HPWM); lo += int'(LPWM);
            tick();
            per++;
        end while (!period_start && per < 10000);
    endtask

    task automatic wait_count(input int v);
        int n;
        n = 0;
        while (int'(count) != v && n < 100) begin tick(); n++; end
        chk("wait_count", int'(count), v);
    endtask

    initial begin
        int per, hi, lo, n;
        vecs[0] = '{p: 10, d: 4,  exp_per: 10, exp_hi: 4,  exp_lo: 6};
        vecs[1] = '{p: 10, d: 0,  exp_per: 10, exp_hi: 0,  exp_lo: 10};
        vecs[2] = '{p: 10, d: 15, exp_per: 10, exp_hi: 10, exp_lo: 0};
        vecs[3] = '{p: 1,  d: 1,  exp_per: 2,  exp_hi: 1,  exp_lo: 1};
        vecs[4] = '{p: 0,  d: 1,  exp_per: 2,  exp_hi: 1,  exp_lo: 1};
        vecs[5] = '{p: 1,  d: 0,  exp_per: 2,  exp_hi: 0,  exp_lo: 2};
        vecs[6] = '{p: 0,  d: 3,  exp_per: 2,  exp_hi: 2,  exp_lo: 0};
        vecs[7] = '{p: 7,  d: 7,  exp_per: 7,  exp_hi: 7,  exp_lo: 0};

        enable = 1'b0; load = 1'b0; period = '0; duty = '0;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // steady-state table: second window after start is fully settled
        for (int i = 0; i < 8; i++) begin
            enable = 1'b0;
            repeat (2) tick();
            period = R'(vecs[i].p); duty = R'(vecs[i].d); load = 1'b1;
            tick();
            load = 1'b0; enable = 1'b1;
            measure(per, hi, lo);
            measure(per, hi, lo);
            chk($sformatf("vec%0d_period", i), per, vecs[i].exp_per);
            chk($sformatf("vec%0d_high", i), hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_low", i), lo, vecs[i].exp_lo);
        end

        // mid-period reload: old duty finishes, ack lands with period_start
        enable = 1'b0;
        tick();
        period = R'(10); duty = R'(4); load = 1'b1;
        tick();
        load = 1'b0; enable = 1'b1;
        measure(per, hi, lo);
        measure(per, hi, lo);
        chk("run10_4_high", hi, 4);
        wait_count(3);
        duty = R'(7); load = 1'b1;
        tick();
        load = 1'b0;
        n = 0;
        while (!load_ack && n < 20) begin tick(); n++; end
        chk("ack_seen", int'(load_ack), 1);
        chk("ack_with_ps", int'(period_start), 1);
        measure(per, hi, lo);
        chk("reload_high7", hi, 7);
        chk("reload_period", per, 10);

        // load during the TC cycle defers to the following boundary
        wait_count(9);
        duty = R'(2); load = 1'b1;
        tick();
        load = 1'b0;
        measure(per, hi, lo);
        chk("tc_load_old_duty", hi, 7);
        measure(per, hi, lo);
        chk("tc_load_new_duty", hi, 2);

        // enable dropped mid-period
        wait_count(5);
        enable = 1'b0;
        tick();
        chk("drop_hpwm", int'(HPWM), 0);
        chk("drop_lpwm", int'(LPWM), 0);
        chk("drop_count", int'(count), 0);

        // asynchronous reset mid-run, then shadows must be at reset values
        enable = 1'b1;
        repeat (3) tick();
        wait_count(5);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) tick();
        reset_n = 1'b1;
        measure(per, hi, lo);
        measure(per, hi, lo);
        chk("rst_shadow_period", per, PMAX);
        chk("rst_shadow_high", hi, 0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 39) != 0);
            load   = ($urandom_range(0, 7) == 0);
            period = R'($urandom_range(0, 20));
            duty   = R'($urandom_range(0, 25));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpwm_core.md
DPWM_CORE -- requirements
Module: dpwm_core

Interface
REQ-001 Parameter RESOLUTION, default 12, SHALL set the width of the counter, period and duty.
REQ-002 hf_clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 enable  input  1  SHALL run the modulator when high and idle it when low.
REQ-005 period  input  RESOLUTION  SHALL give the requested switching period in hf_clock cycles.
REQ-006 duty  input  RESOLUTION  SHALL give the requested high-side on-time in hf_clock cycles.
REQ-007 load  input  1  SHALL be a one-cycle strobe that captures period/duty into the shadow registers.
REQ-008 HPWM  output  1  SHALL be the high-side PWM that feeds the downstream deadtime stage.
REQ-009 LPWM  output  1  SHALL be the low-side PWM that feeds the downstream deadtime stage.
REQ-010 count  output  RESOLUTION  SHALL expose the current ramp counter value.
REQ-011 period_start  output  1  SHALL pulse for one cycle on the first count of each period.
REQ-012 load_ack  output  1  SHALL pulse for one cycle when the shadow values become active.

Function
REQ-013 FSM states SHALL be IDLE and RUN; IDLE->RUN when enable=1, RUN->IDLE when enable=0, on the next edge.
REQ-014 On the IDLE->RUN edge, the active registers SHALL take the shadow values, count SHALL be 0, and period_start SHALL pulse.
REQ-015 In RUN, count SHALL increment by 1 each cycle and wrap to 0 after period_active-1 (the terminal count, TC).
REQ-016 The effective period SHALL be max(period_active, 2); a period of 0 or 1 runs as 2.
REQ-017 load SHALL register period/duty into the shadow registers on the same edge and set the pending flag.
REQ-018 When pending=1 at TC, the active registers SHALL take the shadow values at the wrap edge, clear pending, and pulse load_ack together with period_start.
REQ-019 A load asserted in the TC cycle SHALL take effect at the following period boundary, not the current one.
REQ-020 A second load before transfer SHALL overwrite the shadow values; only the latest values SHALL transfer.
REQ-021 In RUN, HPWM SHALL be registered as (count < duty_active) and LPWM as its complement, one cycle after count.
REQ-022 duty_active=0 SHALL hold HPWM=0/LPWM=1; duty_active >= effective period SHALL hold HPWM=1/LPWM=0 with no glitch at wrap.
REQ-023 HPWM and LPWM SHALL never be high together in any cycle.
REQ-024 In IDLE, HPWM, LPWM, period_start and load_ack SHALL be 0 and count SHALL be held at 0; loads SHALL still update the shadow registers.
REQ-025 Deassertion of enable mid-period SHALL force HPWM=LPWM=0 on the next edge, abandoning the period.

Reset
REQ-026 While reset_n=0: state=IDLE, count=0, HPWM=0, LPWM=0, period_start=0, load_ack=0, pending=0.
REQ-027 While reset_n=0: shadow and active period = 2^RESOLUTION-1 and duty = 0.
REQ-028 Reset asserted mid-period SHALL clear all outputs immediately (asynchronously).
REQ-029 Reset release SHALL be synchronised internally with a 2-flop synchroniser before it affects the FSM.

Structure
REQ-030 A shared package dpwm_pkg SHALL hold the RESOLUTION default and the FSM state type.
REQ-031 The ramp counter with TC detection and wrap SHALL be a sub-module named dpwm_ramp_counter.
REQ-032 The shadow/active register pair and pending flag SHALL stay in dpwm_core.

Verification
REQ-033 period=10, duty=4, load, then enable -> HPWM high 4 cycles / low 6, repeating every 10; LPWM is the complement; period_start every 10 cycles.
REQ-034 While running 10/4, load with duty=7 mid-period -> the current period stays at 4; the next period has 7 high cycles; load_ack coincides with period_start.
REQ-035 load in the TC cycle with duty=2 -> the next period still uses the old duty; the period after uses 2.
REQ-036 duty=0, then duty=15 with period=10 -> HPWM is constantly 0, then constantly 1 across wraps; there is never a cycle with HPWM=LPWM=1.
REQ-037 period=1 -> a period of 2 is observed; period=0 -> a period of 2 is observed.
REQ-038 enable dropped at count=5 -> HPWM=LPWM=0 on the next cycle and count=0; reset_n pulsed mid-run -> all outputs 0 immediately and shadow registers at their reset values.
